countdown_timer_ctrl: RTL
=========================

// Module: countdown_timer_ctrl
// PURPOSE
//  Countdown-timer controller that sequences the 50 MHz time base into a MM:SS countdown.
//  - Derives a 1 Hz decrement tick and a free-running display scan tick from clk_50mhz.
//    Both are one-cycle enable pulses; no derived clocks leave the block.
//  - Runs an IDLE/RUN/PAUSE/DONE state machine, drives BCD digits to the 7-seg scanner and raises an alarm at 00:00.
// PARAMETERS
//  CLK_HZ      50000000  input clock frequency; sim uses 40
//  TICK_HZ     1         decrement rate; DIV = CLK_HZ/TICK_HZ cycles per tick (DIV >= 2)
//  SCAN_DIV    200000    cycles per scan_tick pulse; sim uses 4
//  ALARM_SECS  5         number of ticks the alarm stays high in DONE; sim uses 2
// PORTS
//  clk_50mhz  in   1  system clock, all logic on posedge
//  rst        in   1  asynchronous, active-high reset
//  start      in   1  one-cycle pulse (debounced upstream): start/pause/resume/acknowledge
//  clear      in   1  one-cycle pulse: abort to IDLE; has priority over start
//  load_min   in   8  BCD minutes {tens,ones}, 00-99
//  load_sec   in   8  BCD seconds {tens,ones}, 00-59
//  min_bcd    out  8  current minutes, BCD
//  sec_bcd    out  8  current seconds, BCD
//  state      out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//  running    out  1  1 while state==RUN
//  alarm      out  1  1 while state==DONE
//  tick_1hz   out  1  one-cycle pulse on each divider wrap
//  scan_tick  out  1  one-cycle pulse every SCAN_DIV cycles, free-running
// BEHAVIOUR
//  Reset (async): state=IDLE; div_cnt, scan_cnt and alarm_cnt = 0; min_bcd = sec_bcd = 8'h00; all 1-bit outputs 0.
//  Load clamp: any BCD digit >9 becomes 9. Seconds tens >5 becomes 5 (e.g. 8'h6C -> 8'h59).
//  IDLE
//   - min_bcd/sec_bcd follow the clamped load values every cycle (preview); div_cnt is held at 0.
//   - start with a nonzero clamped value -> RUN on the next edge.
//   - start with 00:00 -> stay in IDLE.
//  RUN
//   - div_cnt counts 0..DIV-1. tick_1hz=1 in the cycle div_cnt==DIV-1, then div_cnt wraps to 0.
//   - First decrement occurs DIV cycles after the start pulse.
//   - On each tick, decrement MM:SS in BCD with borrow: ones 0->9 borrows tens, sec tens 0->5 borrows minutes.
//     Example: 01:00 -> 00:59; 10:00 -> 09:59.
//   - If the decremented result is 00:00 -> DONE on the same edge; alarm=1 next cycle.
//   - start -> PAUSE.
//  PAUSE
//   - div_cnt, min_bcd and sec_bcd are frozen; no ticks are generated.
//   - start -> RUN, resuming from the frozen div_cnt.
//  DONE
//   - Digits hold 00:00; div_cnt keeps running; alarm_cnt increments on each tick.
//   - When alarm_cnt reaches ALARM_SECS -> IDLE.
//   - start (acknowledge) -> IDLE immediately.
//   - On every DONE->IDLE exit, alarm_cnt clears and digits return to the load preview.
//  clear in any state -> IDLE next edge; div_cnt and alarm_cnt cleared.
//  Simultaneous tick and start in RUN: the decrement commits and state goes to PAUSE.
//   - If that decrement reaches 00:00, DONE wins over PAUSE.
//  scan_tick: scan_cnt counts 0..SCAN_DIV-1 in every state, unaffected by start/clear; only rst stops it.
//  Counter widths: div_cnt and scan_cnt are 32 bits. Comparisons use DIV-1 and SCAN_DIV-1, so there is no off-by-one.
//  Reset asserted mid-RUN: outputs return to reset values asynchronously.
//   - After release, the block sits in IDLE showing the load preview from the first clock edge.
// TESTING (CLK_HZ=40, TICK_HZ=1, SCAN_DIV=4, ALARM_SECS=2)
//  - Load 00:03, start at cycle 0 -> state=01 at cycle 1. tick_1hz at cycles 40/80/120; sec = 02/01/00.
//    State=11 and alarm=1 after cycle 120; alarm falls and state=00 after the 2nd DONE tick (cycle 200).
//  - Load 01:00, start -> after first tick min=00, sec=59. Load 10:00 -> 09:59.
//  - Load 00:05, start, start again 20 cycles later -> PAUSE. Hold 100 cycles: digits unchanged, no tick_1hz.
//    Start -> RUN; next decrement exactly 20 cycles later.
//  - start+clear in the same cycle in RUN -> IDLE. Start with load 00:00 -> stays IDLE.
//    Start and tick in the same cycle -> decrement seen, state=PAUSE.
//  - Load min=8'h7A, sec=8'h6C in IDLE -> min_bcd=8'h79, sec_bcd=8'h59.
//    scan_tick pulses every 4 cycles in all states, including across clear.
//  - rst pulsed mid-RUN (not on a clock edge) -> all outputs 0 within the same cycle.
//    After release: IDLE, preview shown, tick_1hz silent.

Source files
------------

// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown controller: 1 Hz decrement tick, free-running display scan tick and an
// IDLE/RUN/PAUSE/DONE sequencer with a timed alarm at 00:00.
module countdown_timer_ctrl #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned SCAN_DIV   = 200000,
    parameter int unsigned ALARM_SECS = 5
) (
    input  logic       clk_50mhz_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       clear_i,
    input  logic [7:0] load_min_i,
    input  logic [7:0] load_sec_i,
    output logic [7:0] min_bcd_o,
    output logic [7:0] sec_bcd_o,
    output logic [1:0] state_o,
    output logic       running_o,
    output logic       alarm_o,
    output logic       tick_1hz_o,
    output logic       scan_tick_o
);

    localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
    localparam logic [31:0] DivLast  = 32'(DIV - 1);
    localparam logic [31:0] ScanLast = 32'(SCAN_DIV - 1);
    localparam logic [31:0] AlarmLim = 32'(ALARM_SECS);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e      state_q;
    logic [31:0] div_cnt_q;
    logic [31:0] scan_cnt_q;
    logic [31:0] alarm_cnt_q;
    logic [7:0]  min_q;
    logic [7:0]  sec_q;

    logic [7:0]  min_load;
    logic [7:0]  sec_load;
    logic [7:0]  min_dec;
    logic [7:0]  sec_dec;
    logic [31:0] div_next;
    logic        load_nonzero;
    logic        dec_zero;
    logic        tick;
    logic        alarm_expire;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    always_comb begin
        min_load     = {clamp_digit(load_min_i[7:4], 4'd9), clamp_digit(load_min_i[3:0], 4'd9)};
        sec_load     = {clamp_digit(load_sec_i[7:4], 4'd5), clamp_digit(load_sec_i[3:0], 4'd9)};
        load_nonzero = (min_load != 8'h00) || (sec_load != 8'h00);
    end

    // BCD decrement with borrow chain: sec ones -> sec tens (0..5) -> min ones -> min tens.
    always_comb begin
        min_dec = min_q;
        sec_dec = sec_q;
        if (sec_q[3:0] != 4'd0) begin
            sec_dec[3:0] = sec_q[3:0] - 4'd1;
        end else begin
            sec_dec[3:0] = 4'd9;
            if (sec_q[7:4] != 4'd0) begin
                sec_dec[7:4] = sec_q[7:4] - 4'd1;
            end else begin
                sec_dec[7:4] = 4'd5;
                if (min_q[3:0] != 4'd0) begin
                    min_dec[3:0] = min_q[3:0] - 4'd1;
                end else begin
                    min_dec[3:0] = 4'd9;
                    min_dec[7:4] = min_q[7:4] - 4'd1;
                end
            end
        end
        dec_zero = (min_dec == 8'h00) && (sec_dec == 8'h00);
    end

    always_comb begin
        tick         = ((state_q == StRun) || (state_q == StDone)) && (div_cnt_q == DivLast);
        div_next     = tick ? 32'd0 : div_cnt_q + 32'd1;
        alarm_expire = tick && ((alarm_cnt_q + 32'd1) >= AlarmLim);
    end

    always_ff @(posedge clk_50mhz_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            div_cnt_q   <= 32'd0;
            alarm_cnt_q <= 32'd0;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
        end else if (clear_i) begin
            state_q     <= StIdle;
            div_cnt_q   <= 32'd0;
            alarm_cnt_q <= 32'd0;
            min_q       <= min_load;
            sec_q       <= sec_load;
        end else begin
            unique case (state_q)
                StIdle: begin
                    div_cnt_q <= 32'd0;
                    min_q     <= min_load;
                    sec_q     <= sec_load;
                    if (start_i && load_nonzero) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    div_cnt_q <= div_next;
                    if (tick) begin
                        min_q <= min_dec;
                        sec_q <= sec_dec;
                    end
                    // Reaching 00:00 outranks a coincident pause request.
                    if (tick && dec_zero) begin
                        state_q <= StDone;
                    end else if (start_i) begin
                        state_q <= StPause;
                    end
                end
                StPause: begin
                    if (start_i) begin
                        state_q <= StRun;
                    end
                end
                StDone: begin
                    if (start_i || alarm_expire) begin
                        state_q     <= StIdle;
                        div_cnt_q   <= 32'd0;
                        alarm_cnt_q <= 32'd0;
                        min_q       <= min_load;
                        sec_q       <= sec_load;
                    end else begin
                        div_cnt_q <= div_next;
                        if (tick) begin
                            alarm_cnt_q <= alarm_cnt_q + 32'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Display scan runs regardless of state; only reset disturbs its phase.
    always_ff @(posedge clk_50mhz_i or posedge rst_i) begin
        if (rst_i) begin
            scan_cnt_q <= 32'd0;
        end else if (scan_cnt_q == ScanLast) begin
            scan_cnt_q <= 32'd0;
        end else begin
            scan_cnt_q <= scan_cnt_q + 32'd1;
        end
    end

    assign min_bcd_o   = min_q;
    assign sec_bcd_o   = sec_q;
    assign state_o     = state_q;
    assign running_o   = (state_q == StRun);
    assign alarm_o     = (state_q == StDone);
    assign tick_1hz_o  = tick;
    assign scan_tick_o = (scan_cnt_q == ScanLast);

endmodule
